// File: rtl/uart_parity_engine.sv
// Bit-serial RX parity engine: assembles LSB-first data bits of configurable length,
// checks even/odd/mark/space parity and keeps sticky/counted error status.
module uart_parity_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     cfg_parity_en,
  input  logic [1:0]               cfg_mode,
  input  logic [3:0]               cfg_data_len,
  input  logic                     parity_fault_injection,
  input  logic                     frame_start,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  input  logic                     clr_err,
  output logic                     frame_done,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     PARITYERR,
  output logic                     err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

  state_t                   state_reg, state_next;
  logic [3:0]               bit_cnt_reg;
  logic [3:0]               len_reg;
  logic [DATA_WIDTH-1:0]    shift_reg;
  logic                     acc_reg;
  logic                     par_en_reg;
  logic [1:0]               mode_reg;
  logic                     err_r_reg;
  logic                     err_sticky_reg;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;

  logic [3:0]               len_clamped;
  logic                     last_bit;
  logic                     expected_par;
  logic                     rx_par;
  logic [DATA_WIDTH-1:0]    bit_sel;

  assign len_clamped = ((cfg_data_len == 4'd0) || (cfg_data_len > MAX_LEN)) ? MAX_LEN : cfg_data_len;
  assign last_bit    = (bit_cnt_reg == (len_reg - 4'd1));
  assign rx_par      = bit_in ^ parity_fault_injection;

  // One-hot write strobe for the data bit at position bit_cnt
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_sel
      assign bit_sel[gi] = (bit_cnt_reg == 4'(gi));
    end
  endgenerate

  always_comb begin
    expected_par = 1'b0;
    case (mode_reg)
      2'b00:   expected_par = acc_reg;
      2'b01:   expected_par = ~acc_reg;
      2'b10:   expected_par = 1'b1;
      default: expected_par = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (frame_start) begin
      state_next = ST_DATA;
    end else begin
      case (state_reg)
        ST_DATA: begin
          if (bit_valid && last_bit) begin
            state_next = par_en_reg ? ST_PARITY : ST_DONE;
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_done = (state_reg == ST_DONE);
    PARITYERR  = (state_reg == ST_DONE) && err_r_reg;
    data_out   = shift_reg;
    err_sticky = err_sticky_reg;
    err_count  = err_cnt_reg;
  end

  // Frame datapath; frame_start restarts everything and masks a coincident bit
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      bit_cnt_reg <= 4'd0;
      len_reg     <= MAX_LEN;
      shift_reg   <= '0;
      acc_reg     <= 1'b0;
      par_en_reg  <= 1'b0;
      mode_reg    <= 2'b00;
      err_r_reg   <= 1'b0;
    end else if (frame_start) begin
      bit_cnt_reg <= 4'd0;
      len_reg     <= len_clamped;
      shift_reg   <= '0;
      acc_reg     <= 1'b0;
      par_en_reg  <= cfg_parity_en;
      mode_reg    <= cfg_mode;
      err_r_reg   <= 1'b0;
    end else begin
      if ((state_reg == ST_DATA) && bit_valid) begin
        shift_reg   <= shift_reg | (bit_sel & {DATA_WIDTH{bit_in}});
        acc_reg     <= acc_reg ^ bit_in;
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
      end
      if ((state_reg == ST_PARITY) && bit_valid) begin
        err_r_reg <= (rx_par != expected_par) && par_en_reg;
      end
    end
  end

  // Status: a clear coinciding with an error leaves exactly that one error recorded
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_sticky_reg <= 1'b0;
      err_cnt_reg    <= '0;
    end else if ((state_reg == ST_DONE) && err_r_reg) begin
      err_sticky_reg <= 1'b1;
      if (clr_err) begin
        err_cnt_reg <= ERR_CNT_WIDTH'(1);
      end else if (!(&err_cnt_reg)) begin
        err_cnt_reg <= err_cnt_reg + ERR_CNT_WIDTH'(1);
      end
    end else if (clr_err) begin
      err_sticky_reg <= 1'b0;
      err_cnt_reg    <= '0;
    end
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine: directed scenarios plus randomized frames
// checked against a frame-level parity model.
module tb_uart_parity_engine;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       cfg_parity_en = 1'b0;
  logic [1:0] cfg_mode = 2'b00;
  logic [3:0] cfg_data_len = 4'd0;
  logic       parity_fault_injection = 1'b0;
  logic       frame_start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       clr_err = 1'b0;

  logic       frame_done, PARITYERR, err_sticky;
  logic [7:0] data_out, err_count;
  logic       frame_done_s, parityerr_s, err_sticky_s;
  logic [7:0] data_out_s;
  logic [1:0] err_count_s;

  int checks = 0;
  int errors = 0;
  int m_cnt8 = 0;
  int m_cnt2 = 0;
  logic m_sticky = 1'b0;
  logic started = 1'b0;
  logic [3:0] nxt_len;
  logic       nxt_pen;
  logic [1:0] nxt_mode;

  always #5 HCLK = ~HCLK;

  uart_parity_engine dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_parity_en(cfg_parity_en), .cfg_mode(cfg_mode),
    .cfg_data_len(cfg_data_len), .parity_fault_injection(parity_fault_injection),
    .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in), .clr_err(clr_err),
    .frame_done(frame_done), .data_out(data_out), .PARITYERR(PARITYERR),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  uart_parity_engine #(.ERR_CNT_WIDTH(2)) dut_s (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_parity_en(cfg_parity_en), .cfg_mode(cfg_mode),
    .cfg_data_len(cfg_data_len), .parity_fault_injection(parity_fault_injection),
    .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in), .clr_err(clr_err),
    .frame_done(frame_done_s), .data_out(data_out_s), .PARITYERR(parityerr_s),
    .err_sticky(err_sticky_s), .err_count(err_count_s)
  );

  task automatic check_status(input string name);
    checks++;
    if (err_count !== 8'(m_cnt8) || err_count_s !== 2'(m_cnt2) || err_sticky !== m_sticky) begin
      errors++;
      $display("FAIL %s: err_count=%0d/%0d sticky=%0b, required %0d/%0d sticky=%0b",
               name, err_count, err_count_s, err_sticky, m_cnt8, m_cnt2, m_sticky);
    end
  endtask

  // One full frame; bad flips the transmitted parity bit away from the correct value
  task automatic run_frame(input logic [7:0] data, input logic [3:0] len, input logic pen,
                           input logic [1:0] mode, input logic bad, input logic inj,
                           input logic clr, input logic gaps, input logic chain_next);
    int eff;
    logic [7:0] exp_data;
    logic exp_par, perr;
    eff = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
    exp_data = 8'(int'(data) & ((1 << eff) - 1));
    case (mode)
      2'b00:   exp_par = ^exp_data;
      2'b01:   exp_par = ~(^exp_data);
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
    perr = pen & (bad ^ inj);
    if (!started) begin
      frame_start = 1'b1; cfg_data_len = len; cfg_parity_en = pen; cfg_mode = mode;
      bit_valid = 1'($urandom); bit_in = 1'($urandom);
      @(negedge HCLK);
    end
    started = 1'b0;
    frame_start = 1'b0;
    cfg_data_len = 4'($urandom); cfg_parity_en = 1'($urandom); cfg_mode = 2'($urandom);
    for (int i = 0; i < eff; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bit_valid = 1'b0; bit_in = 1'($urandom); parity_fault_injection = 1'($urandom);
          @(negedge HCLK);
          checks++;
          if (frame_done !== 1'b0) begin
            errors++; $display("FAIL gap_done: frame_done=%0b required 0", frame_done);
          end
        end
      end
      bit_valid = 1'b1; bit_in = data[i]; parity_fault_injection = 1'($urandom);
      @(negedge HCLK);
      checks++;
      if (frame_done !== ((i == eff - 1) && !pen)) begin
        errors++;
        $display("FAIL data_done bit %0d: frame_done=%0b required %0b", i, frame_done, (i == eff - 1) && !pen);
      end
    end
    if (pen) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bit_valid = 1'b0; bit_in = 1'($urandom);
          @(negedge HCLK);
          checks++;
          if (frame_done !== 1'b0) begin
            errors++; $display("FAIL par_gap_done: frame_done=%0b required 0", frame_done);
          end
        end
      end
      bit_valid = 1'b1; bit_in = exp_par ^ bad; parity_fault_injection = inj;
      @(negedge HCLK);
      checks++;
      if (frame_done !== 1'b1) begin
        errors++; $display("FAIL par_done: frame_done=%0b required 1", frame_done);
      end
    end
    checks++;
    if (data_out !== exp_data || PARITYERR !== perr) begin
      errors++;
      $display("FAIL done_out: data_out=%02h perr=%0b required %02h perr=%0b", data_out, PARITYERR, exp_data, perr);
    end
    check_status("status_before_update");
    parity_fault_injection = 1'($urandom); bit_valid = 1'($urandom); bit_in = 1'($urandom);
    clr_err = clr;
    if (chain_next) begin
      frame_start = 1'b1; cfg_data_len = nxt_len; cfg_parity_en = nxt_pen; cfg_mode = nxt_mode;
      started = 1'b1;
    end
    @(negedge HCLK);
    if (perr) begin
      m_cnt8 = clr ? 1 : (m_cnt8 < 255 ? m_cnt8 + 1 : 255);
      m_cnt2 = clr ? 1 : (m_cnt2 < 3 ? m_cnt2 + 1 : 3);
      m_sticky = 1'b1;
    end else if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0; m_sticky = 1'b0;
    end
    clr_err = 1'b0; bit_valid = 1'b0;
    check_status("status_after_done");
    if (!chain_next) begin
      checks++;
      if (frame_done !== 1'b0 || PARITYERR !== 1'b0 || data_out !== exp_data) begin
        errors++;
        $display("FAIL post_done: done=%0b perr=%0b data=%02h required 0 0 %02h", frame_done, PARITYERR, data_out, exp_data);
      end
    end
    $display("frame data=%02h len=%0d pen=%0b mode=%0d bad=%0b inj=%0b clr=%0b chain=%0b -> perr=%0b cnt=%0d",
             data, len, pen, mode, bad, inj, clr, chain_next, perr, m_cnt8);
  endtask

  task automatic send_partial(input int n, input logic [3:0] len, input logic pen);
    frame_start = 1'b1; cfg_data_len = len; cfg_parity_en = pen; cfg_mode = 2'($urandom);
    bit_valid = 1'b0;
    @(negedge HCLK);
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1; bit_in = 1'($urandom);
      @(negedge HCLK);
      checks++;
      if (frame_done !== 1'b0) begin
        errors++; $display("FAIL partial_done: frame_done=%0b required 0", frame_done);
      end
    end
    bit_valid = 1'b0;
    $display("partial frame: %0d bits len=%0d pen=%0b", n, len, pen);
  endtask

  task automatic test_reset();
    HRESET = 1'b1; frame_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; clr_err = 1'($urandom);
    repeat (2) @(negedge HCLK);
    m_cnt8 = 0; m_cnt2 = 0; m_sticky = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || data_out !== 8'h00 || PARITYERR !== 1'b0) begin
      errors++; $display("FAIL reset_out: done=%0b data=%02h perr=%0b required 0 00 0", frame_done, data_out, PARITYERR);
    end
    check_status("reset_status");
    HRESET = 1'b0; frame_start = 1'b0; clr_err = 1'b0;
    repeat (4) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      @(negedge HCLK);
      checks++;
      if (frame_done !== 1'b0 || data_out !== 8'h00) begin
        errors++; $display("FAIL reset_idle: done=%0b data=%02h required 0 00", frame_done, data_out);
      end
    end
    bit_valid = 1'b0;
    $display("reset applied and idle verified");
  endtask

  task automatic test_even_a5();
    run_frame(8'hA5, 4'd8, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_odd_41();
    run_frame(8'h41, 4'd7, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mark_space();
    run_frame(8'h00, 4'd8, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h00, 4'd8, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(8'h00, 4'd8, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_no_parity();
    run_frame(8'h96, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(8'h5A, 4'd12, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    send_partial(3, 4'd8, 1'b1);
    run_frame(8'h3C, 4'd8, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_partial(5, 4'd5, 1'b1);
    run_frame(8'h3C, 4'd8, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    nxt_len = 4'd6; nxt_pen = 1'b1; nxt_mode = 2'b01;
    run_frame(8'hC3, 4'd8, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nxt_len = 4'd5; nxt_pen = 1'b0; nxt_mode = 2'b10;
    run_frame(8'h2D, 4'd6, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_frame(8'h17, 4'd5, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_counter();
    clr_err = 1'b1;
    @(negedge HCLK);
    clr_err = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0; m_sticky = 1'b0;
    check_status("clr_idle");
    for (int k = 0; k < 5; k++) begin
      run_frame(8'(k * 37), 4'd8, 1'b1, 2'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_frame(8'hE7, 4'd8, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    send_partial(3, 4'd8, 1'b1);
    test_reset();
  endtask

  task automatic test_random();
    logic [3:0] len;
    logic pen, bad, inj, chain;
    logic [1:0] mode;
    for (int n = 0; n < 40; n++) begin
      if (started) begin
        len = nxt_len; pen = nxt_pen; mode = nxt_mode;
      end else begin
        len = 4'($urandom); pen = 1'($urandom); mode = 2'($urandom);
      end
      bad = 1'($urandom); inj = 1'($urandom);
      chain = (n < 39) && ($urandom_range(0, 3) == 0);
      if (chain) begin
        inj = bad;
        nxt_len = 4'($urandom); nxt_pen = 1'($urandom); nxt_mode = 2'($urandom);
      end
      run_frame(8'($urandom), len, pen, mode, bad, inj, 1'($urandom_range(0, 7) == 0),
                1'($urandom), chain);
    end
  endtask

  initial begin
    @(negedge HCLK);
    test_reset();
    test_even_a5();
    test_odd_41();
    test_mark_space();
    test_no_parity();
    test_abort();
    test_back_to_back();
    test_counter();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
